// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared op codes, states and dimension field layout for the matrix-multiply sequencer
package mm_pkg;
    localparam int MAX_DIM = 1024;
    localparam int LANES   = 8;
    localparam int LANE_SH = $clog2(LANES);
    localparam int DIM_W   = 11;

    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    localparam logic [2:0] OP_DIM = 3'd0;
    localparam logic [2:0] OP_A   = 3'd1;
    localparam logic [2:0] OP_B   = 3'd2;
    localparam logic [2:0] OP_C   = 3'd3;
    localparam logic [2:0] OP_MAC = 3'd4;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam int M_LSB = 0;
    localparam int M_MSB = 10;
    localparam int N_LSB = 11;
    localparam int N_MSB = 21;
    localparam int O_LSB = 22;
    localparam int O_MSB = 31;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIM_ADR,
        S_DIM_RD,
        S_CHECK,
        S_A_ADR,
        S_A_RD,
        S_B_ADR,
        S_B_RD,
        S_MAC,
        S_MAC_WAIT,
        S_C_ADR,
        S_C_WR,
        S_DONE_CHK,
        S_ERR
    } state_t;
endpackage

// File: rtl/mm_loop_ctr.sv
// rtl/mm_loop_ctr.sv - nested row / C-block / K-chunk / B-row counter chain with last-flags
module mm_loop_ctr
    import mm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] cb,
    input  logic [DIM_W-1:0] kb,
    input  logic             brow_step,
    input  logic             kblk_step,
    input  logic             cblk_step,
    output logic [2:0]       brow_cnt,
    output logic             brow_last,
    output logic             kblk_last,
    output logic             cblk_last,
    output logic             row_last
);
    logic [DIM_W-1:0] kblk_cnt;
    logic [DIM_W-1:0] cblk_cnt;
    logic [DIM_W-1:0] row_cnt;

    assign brow_last = (brow_cnt == 3'd7);
    assign kblk_last = (kblk_cnt == kb - DIM_ONE);
    assign cblk_last = (cblk_cnt == cb - DIM_ONE);
    assign row_last  = (row_cnt == m - DIM_ONE);

    // Each counter wraps itself on its last value; the row advances when a C-block sweep wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            brow_cnt <= '0;
            kblk_cnt <= '0;
            cblk_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            if (brow_step) begin
                brow_cnt <= brow_last ? 3'd0 : brow_cnt + 3'd1;
            end
            if (kblk_step) begin
                kblk_cnt <= kblk_last ? '0 : kblk_cnt + DIM_ONE;
            end
            if (cblk_step) begin
                if (cblk_last) begin
                    cblk_cnt <= '0;
                    row_cnt  <= row_last ? '0 : row_cnt + DIM_ONE;
                end else begin
                    cblk_cnt <= cblk_cnt + DIM_ONE;
                end
            end
        end
    end
endmodule

// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - op-code / memory-strobe sequencer walking the A-row, C-block, K-chunk and B-row loops
module mm_sequencer
    import mm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [2:0]   inst,
    output logic         dim_we,
    output logic [255:0] dim_out,
    output logic         dmem_re,
    output logic         dmem_we,
    input  logic         dmem_ack,
    input  logic [255:0] dmem_rdata,
    output logic         a_load,
    output logic         b_load,
    output logic [2:0]   b_row,
    input  logic         mac_done,
    input  logic         mm_complete,
    output logic         busy,
    output logic         done,
    output logic         err
);
    state_t state, state_nxt;

    logic [255:0]     dim_reg;
    logic [DIM_W-1:0] m, n, o, kb, cb;
    logic             dims_bad;
    logic             clear_ctr, brow_step, kblk_step, cblk_step;
    logic             brow_last, kblk_last, cblk_last, row_last;

    assign dim_out = dim_reg;
    assign m  = dim_reg[M_MSB:M_LSB];
    assign n  = dim_reg[N_MSB:N_LSB];
    assign o  = {1'b0, dim_reg[O_MSB:O_LSB]};
    assign kb = n >> LANE_SH;
    assign cb = o >> LANE_SH;

    assign dims_bad = (m == '0) || (n == '0) || (o == '0)
                   || (n[LANE_SH-1:0] != '0) || (o[LANE_SH-1:0] != '0)
                   || (m > DIM_MAX) || (n > DIM_MAX) || (o > DIM_MAX);

    assign busy = (state != S_IDLE);

    mm_loop_ctr u_loop_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_ctr),
        .m         (m),
        .cb        (cb),
        .kb        (kb),
        .brow_step (brow_step),
        .kblk_step (kblk_step),
        .cblk_step (cblk_step),
        .brow_cnt  (b_row),
        .brow_last (brow_last),
        .kblk_last (kblk_last),
        .cblk_last (cblk_last),
        .row_last  (row_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            dim_reg <= '0;
            dim_we  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_nxt;
            dim_we <= (state == S_DIM_RD) && dmem_ack;
            if (state == S_DIM_RD && dmem_ack) begin
                dim_reg <= dmem_rdata;
            end
            if (state == S_IDLE && start) begin
                err <= 1'b0;
            end else if (state == S_ERR || (state == S_DONE_CHK && !mm_complete)) begin
                err <= 1'b1;
            end
        end
    end

    // Every *_ADR state is one cycle and is always followed by a state driving NOP,
    // so repeated identical op codes still appear as edges to the control unit.
    always_comb begin
        state_nxt = state;
        inst      = OP_NOP;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        a_load    = 1'b0;
        b_load    = 1'b0;
        done      = 1'b0;
        clear_ctr = 1'b0;
        brow_step = 1'b0;
        kblk_step = 1'b0;
        cblk_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_DIM_ADR;
                    clear_ctr = 1'b1;
                end
            end
            S_DIM_ADR: begin
                inst      = OP_DIM;
                state_nxt = S_DIM_RD;
            end
            S_DIM_RD: begin
                dmem_re = 1'b1;
                if (dmem_ack) state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = dims_bad ? S_ERR : S_A_ADR;
            S_A_ADR: begin
                inst      = OP_A;
                state_nxt = S_A_RD;
            end
            S_A_RD: begin
                dmem_re = 1'b1;
                if (dmem_ack) begin
                    a_load    = 1'b1;
                    state_nxt = S_B_ADR;
                end
            end
            S_B_ADR: begin
                inst      = OP_B;
                state_nxt = S_B_RD;
            end
            S_B_RD: begin
                dmem_re = 1'b1;
                if (dmem_ack) begin
                    b_load    = 1'b1;
                    brow_step = 1'b1;
                    state_nxt = brow_last ? S_MAC : S_B_ADR;
                end
            end
            S_MAC: begin
                inst      = OP_MAC;
                state_nxt = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                if (mac_done) begin
                    kblk_step = 1'b1;
                    state_nxt = kblk_last ? S_C_ADR : S_A_ADR;
                end
            end
            S_C_ADR: begin
                inst      = OP_C;
                state_nxt = S_C_WR;
            end
            S_C_WR: begin
                dmem_we = 1'b1;
                if (dmem_ack) begin
                    cblk_step = 1'b1;
                    state_nxt = (cblk_last && row_last) ? S_DONE_CHK : S_A_ADR;
                end
            end
            S_DONE_CHK: begin
                done      = mm_complete;
                state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - scoreboard bench for mm_sequencer
module tb_mm_sequencer;
    import mm_pkg::*;

    logic         clk = 1'b0;
    logic         reset, start, dmem_ack, mac_done, mm_complete;
    logic [255:0] dmem_rdata;
    logic [2:0]   inst, b_row;
    logic         dim_we, dmem_re, dmem_we, a_load, b_load, busy, done, err;
    logic [255:0] dim_out;

    always #5 clk = ~clk;

    mm_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .inst        (inst),
        .dim_we      (dim_we),
        .dim_out     (dim_out),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .a_load      (a_load),
        .b_load      (b_load),
        .b_row       (b_row),
        .mac_done    (mac_done),
        .mm_complete (mm_complete),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;
    int exp_ops[$];
    int exp_brow[$];
    int exp_res[$];
    logic [255:0] exp_dim[$];
    int reads = 0, writes = 0, macs = 0, dones = 0;
    bit rand_lat = 0;
    int fixed_lat = 0;
    bit spur_en = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: ack after 'lat' waiting cycles (0 = same-cycle ack).
    initial begin
        int  lat, wcnt;
        bit  in_req;
        dmem_ack = 1'b0;
        in_req = 0; lat = 0; wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (dmem_ack || reset) begin
                dmem_ack = 1'b0;
                in_req = 0;
            end else if (dmem_re || dmem_we) begin
                if (!in_req) begin
                    in_req = 1;
                    wcnt = 0;
                    lat = rand_lat ? int'($urandom_range(0, 5)) : fixed_lat;
                end
                if (wcnt >= lat) dmem_ack = 1'b1;
                else wcnt++;
            end else begin
                in_req = 0;
            end
        end
    end

    // MAC array model: mac_done two cycles after inst=4; optional stray pulse while dim_we is high.
    initial begin
        int dly;
        mac_done = 1'b0;
        dly = 0;
        forever begin
            @(posedge clk); #1;
            mac_done = 1'b0;
            if (reset) dly = 0;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) mac_done = 1'b1;
            end else if (inst == OP_MAC) dly = 2;
            if (spur_en && dim_we) mac_done = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an op, a B row, a dim word or a result.
    initial begin
        int  prev_inst, res;
        bit  prev_re, prev_we, prev_ack, prev_err;
        prev_inst = 7; prev_re = 0; prev_we = 0; prev_ack = 0; prev_err = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_inst = 7; prev_re = 0; prev_we = 0; prev_ack = 0; prev_err = 0;
            end else begin
                if (inst != OP_NOP) begin
                    check("nop_gap", prev_inst, 7);
                    if (exp_ops.size() == 0) check("extra_op", inst, OP_NOP);
                    else check("op", inst, exp_ops.pop_front());
                    if (inst == OP_MAC) macs++;
                end
                if (dmem_ack && dmem_re) reads++;
                if (dmem_ack && dmem_we) writes++;
                if (prev_re && !prev_ack) check("re_held", dmem_re, 1);
                if (prev_we && !prev_ack) check("we_held", dmem_we, 1);
                if (b_load) begin
                    if (exp_brow.size() == 0) check("extra_bload", b_load, 0);
                    else check("b_row", b_row, exp_brow.pop_front());
                end
                if (dim_we) begin
                    if (exp_dim.size() == 0) check("extra_dim_we", dim_we, 0);
                    else check("dim_out", dim_out, exp_dim.pop_front());
                end
                if (done) dones++;
                if (done || (err && !prev_err)) begin
                    res = done ? 1 : 2;
                    if (exp_res.size() == 0) check("extra_result", res, 0);
                    else check("result", res, exp_res.pop_front());
                end
                prev_inst = int'(inst);
                prev_re = dmem_re; prev_we = dmem_we; prev_ack = dmem_ack; prev_err = err;
            end
        end
    end

    task automatic push_run(input int m, input int n, input int o, input bit ok, input bit fin);
        logic [255:0] d;
        d = '0;
        d[10:0]  = m[10:0];
        d[21:11] = n[10:0];
        d[31:22] = o[9:0];
        dmem_rdata = d;
        exp_dim.push_back(d);
        exp_ops.push_back(0);
        if (ok) begin
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < o / 8; c++) begin
                    for (int k = 0; k < n / 8; k++) begin
                        exp_ops.push_back(1);
                        for (int b = 0; b < 8; b++) begin
                            exp_ops.push_back(2);
                            exp_brow.push_back(b);
                        end
                        exp_ops.push_back(4);
                    end
                    exp_ops.push_back(3);
                end
            end
        end
        exp_res.push_back((ok && fin) ? 1 : 2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input int m, input int n, input int o, input bit ok,
                       input bit fin, input bit poke, input int er, input int ew, input int em);
        int r0, w0, m0, d0, cyc;
        r0 = reads; w0 = writes; m0 = macs; d0 = dones;
        push_run(m, n, o, ok, fin);
        @(posedge clk); #1;
        pulse_start();
        check({tag, "_err_clr"}, err, 0);
        check({tag, "_busy"}, busy, 1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            pulse_start();
        end
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_busy_fall"}, busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_reads"}, reads - r0, er);
        check({tag, "_writes"}, writes - w0, ew);
        check({tag, "_macs"}, macs - m0, em);
        check({tag, "_dones"}, dones - d0, (ok && fin) ? 1 : 0);
        check({tag, "_err"}, err, (ok && fin) ? 0 : 1);
        check({tag, "_ops_left"}, exp_ops.size(), 0);
        check({tag, "_res_left"}, exp_res.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_inst"}, inst, OP_NOP);
        check({tag, "_re"}, dmem_re, 0);
        check({tag, "_we"}, dmem_we, 0);
        check({tag, "_aload"}, a_load, 0);
        check({tag, "_bload"}, b_load, 0);
        check({tag, "_dimwe"}, dim_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_brow"}, b_row, 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; mm_complete = 1'b1; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_dim_out", dim_out, 0);
        reset = 1'b0;

        run("t1", 1, 8, 8, 1, 1, 0, 10, 1, 1);
        spur_en = 1;
        run("t2", 2, 16, 16, 1, 1, 0, 73, 4, 8);
        spur_en = 0;
        run("t3", 1, 12, 8, 0, 1, 0, 1, 0, 0);
        run("t3b", 1025, 8, 8, 0, 1, 0, 1, 0, 0);
        rand_lat = 1;
        run("t4", 1, 8, 16, 1, 1, 0, 19, 2, 2);
        rand_lat = 0;

        fixed_lat = 3;
        push_run(2, 16, 16, 1, 1);
        @(posedge clk); #1;
        pulse_start();
        cyc = 0;
        while (inst != OP_B && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t5_reach_b", inst, OP_B);
        @(posedge clk); #1;
        check("t5_in_b_rd", dmem_re, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("t5_rst");
        reset = 1'b0;
        exp_ops.delete(); exp_brow.delete(); exp_res.delete(); exp_dim.delete();
        fixed_lat = 0;
        run("t5_rerun", 1, 8, 8, 1, 1, 0, 10, 1, 1);

        mm_complete = 1'b0;
        run("t6", 1, 8, 8, 1, 0, 1, 10, 1, 1);
        mm_complete = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
Top-level sequencer for the matrix-multiply accelerator, sitting directly upstream of the accelerator control/address unit. It drives the 3-bit operation code, dimension write-enable and data-memory read/write strobes, and walks the A-row / C-block / K-chunk / B-row loops. It tags returning read data so the MAC array knows whether each word is the dimension word, an A chunk or a B row.
Loop order: for each A row, for each 8-word C block, for each 8-word K chunk: load A, load 8 B rows, MAC. After all K chunks of a C block, store C.

Parameters:
MAX_DIM, 1024, largest legal m, n or o; larger values raise err.
LANES, 8, words per 256-bit memory beat; n and o must be multiples of this.

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a multiply when idle, ignored when busy
inst  out  3  op code to control unit: 0 dim addr, 1 A addr, 2 B addr, 3 C store addr, 4 MAC enable, 7 NOP
dim_we  out  1  one-cycle strobe latching dim word into control unit
dim_out  out  256  captured dimension beat, forwarded with dim_we
dmem_re  out  1  read request, held until dmem_ack
dmem_we  out  1  write request for C, held until dmem_ack
dmem_ack  in  1  memory accepted/returned beat
dmem_rdata  in  256  read data, valid with dmem_ack on a read
a_load  out  1  strobe: dmem_rdata is an A chunk
b_load  out  1  strobe: dmem_rdata is B row b_row
b_row  out  3  B row index within chunk (0..7)
mac_done  in  1  MAC array finished one 8x8 chunk
mm_complete  in  1  completion flag from control unit
busy  out  1  high from accepted start until DONE/ERR
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky until next start; illegal dims or completion mismatch

Behaviour:
Reset values: all outputs 0, except inst = 7. All counters 0, state IDLE. Reset mid-operation aborts immediately with no further memory strobes.

Op-code issue rule: every inst value other than 7 is driven for exactly one cycle and then followed by at least one cycle of 7. This guarantees that identical consecutive codes (e.g. repeated 2) are seen as changes by the control unit.

Dimension fields: m = dim[10:0], n = dim[21:11], o = dim[31:22]. Loop limits are KB = n/8 and CB = o/8, computed with 11-bit shifts, no division.

State machine:
- IDLE: on start, go to DIM_ADR and clear err.
- DIM_ADR: inst=0, then DIM_RD.
- DIM_RD: hold dmem_re until dmem_ack. On ack, capture rdata, pulse dim_we next cycle, go to CHECK.
- CHECK: go to ERR if any of m,n,o is 0, if n[2:0]!=0 or o[2:0]!=0, or if any exceeds MAX_DIM. Otherwise go to A_ADR.
- A_ADR: inst=1, then A_RD.
- A_RD: read handshake; a_load pulses with ack; go to B_ADR.
- B_ADR: inst=2, then B_RD.
- B_RD: read handshake; b_load pulses with ack and b_row = brow_cnt. If brow_cnt==7, clear it and go to MAC; else increment and go to B_ADR.
- MAC: inst=4 for one cycle, then MAC_WAIT.
- MAC_WAIT: wait for mac_done. If kblk_cnt==KB-1, clear it and go to C_ADR; else increment and go to A_ADR.
- C_ADR: inst=3, then C_WR.
- C_WR: hold dmem_we until dmem_ack, then advance cblk_cnt and row_cnt. Go to DONE_CHK when the last C block of the last row is written, else A_ADR.
- DONE_CHK: wait 1 cycle. If mm_complete=1, pulse done; else set err. Either way go to IDLE.
- ERR: set err, go to IDLE.

Boundary and simultaneity rules:
- dmem_ack arriving in the same cycle as the request is legal (zero-wait memory).
- A start pulse while busy is ignored.
- mac_done outside MAC_WAIT is ignored.
- Total reads per run: 1 + m·CB·KB·9. Total writes: m·CB.

Decomposition:
- Shared package mm_pkg holds the op-code constants (OP_DIM=0, OP_A=1, OP_B=2, OP_C=3, OP_MAC=4, OP_NOP=7), the state enum, and the dim field slice positions.
- Natural sub-module: mm_loop_ctr, the nested row/cblk/kblk/brow counter chain. It takes m, CB, KB and step/clear inputs and produces last-flags.

Test Plan:
1. dim m=1,n=8,o=8, zero-wait memory, mac_done 2 cycles after inst=4 -> inst sequence 0,1,2×8,4,3 (NOPs between); 10 reads, 1 write; done pulses once; err=0.
2. m=2,n=16,o=16 -> 1+2·2·2·9=73 reads, 4 writes, 8 MAC enables; b_row cycles 0..7 per chunk; done.
3. n=12 -> err=1 after CHECK; no inst other than 0/7 issued; busy falls; no dmem_we.
4. Random 0-5 cycle dmem_ack latency on m=1,n=8,o=16 -> dmem_re/we held stable until ack; same op sequence as the zero-wait run.
5. Reset asserted in B_RD of test 2 -> next cycle inst=7 and all strobes 0; a new start runs cleanly to done.
6. mm_complete held 0 through test 1 -> err=1 and no done; start pulsed while busy has no effect.
